// File: rtl/patient_alert_pkg.sv
// Shared constants, alert codes, FSM state type and mask helpers for the patient alert arbiter.
package patient_alert_pkg;

    localparam int unsigned NUM_SRC = 5;
    localparam int unsigned CODE_W  = 3;

    localparam logic [CODE_W-1:0] CODE_NONE    = 3'd0;
    localparam logic [CODE_W-1:0] CODE_FALL    = 3'd1;
    localparam logic [CODE_W-1:0] CODE_BPM     = 3'd2;
    localparam logic [CODE_W-1:0] CODE_TEMP_HI = 3'd3;
    localparam logic [CODE_W-1:0] CODE_TEMP_LO = 3'd4;
    localparam logic [CODE_W-1:0] CODE_MED     = 3'd5;

    localparam int unsigned SRC_FALL    = 0;
    localparam int unsigned SRC_BPM     = 1;
    localparam int unsigned SRC_TEMP_HI = 2;
    localparam int unsigned SRC_TEMP_LO = 3;
    localparam int unsigned SRC_MED     = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ALERT   = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    // One-hot pending bit belonging to an alert code.
    function automatic logic [NUM_SRC-1:0] code_bit(input logic [CODE_W-1:0] code);
        logic [NUM_SRC-1:0] m;
        m = '0;
        case (code)
            CODE_FALL:    m[SRC_FALL]    = 1'b1;
            CODE_BPM:     m[SRC_BPM]     = 1'b1;
            CODE_TEMP_HI: m[SRC_TEMP_HI] = 1'b1;
            CODE_TEMP_LO: m[SRC_TEMP_LO] = 1'b1;
            CODE_MED:     m[SRC_MED]     = 1'b1;
            default:      m              = '0;
        endcase
        return m;
    endfunction

    // Pending bits that outrank the given code (lower bit index wins).
    function automatic logic [NUM_SRC-1:0] higher_mask(input logic [CODE_W-1:0] code);
        logic [NUM_SRC-1:0] m;
        m = '0;
        case (code)
            CODE_BPM:     m = 5'b00001;
            CODE_TEMP_HI: m = 5'b00011;
            CODE_TEMP_LO: m = 5'b00111;
            CODE_MED:     m = 5'b01111;
            default:      m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/alert_prio_enc.sv
// Fixed-priority encoder: lowest set pending bit to alert code plus valid flag.
module alert_prio_enc
    import patient_alert_pkg::*;
(
    input  logic [NUM_SRC-1:0] i_pending,
    output logic [CODE_W-1:0]  o_code_c,
    output logic               o_valid_c
);

    // Fall outranks bpm, then temp_high, temp_low, medicine.
    always_comb begin
        o_code_c  = CODE_NONE;
        o_valid_c = 1'b0;
        if (i_pending[SRC_FALL]) begin
            o_code_c  = CODE_FALL;
            o_valid_c = 1'b1;
        end else if (i_pending[SRC_BPM]) begin
            o_code_c  = CODE_BPM;
            o_valid_c = 1'b1;
        end else if (i_pending[SRC_TEMP_HI]) begin
            o_code_c  = CODE_TEMP_HI;
            o_valid_c = 1'b1;
        end else if (i_pending[SRC_TEMP_LO]) begin
            o_code_c  = CODE_TEMP_LO;
            o_valid_c = 1'b1;
        end else if (i_pending[SRC_MED]) begin
            o_code_c  = CODE_MED;
            o_valid_c = 1'b1;
        end
    end

endmodule

// File: rtl/patient_alert_arbiter.sv
// Shares one caregiver alert channel among the patient monitors: edge-latches
// requests, serves them in fixed priority, waits for ack, escalates on timeout.
module patient_alert_arbiter
    import patient_alert_pkg::*;
#(
    parameter int unsigned ESC_CYCLES     = 30_000_000,
    parameter int unsigned HOLDOFF_CYCLES = 1000,
    parameter int unsigned BEEP_HALF      = 500_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fall_alarm,
    input  logic               bpm_abnormal,
    input  logic               temp_high,
    input  logic               temp_low,
    input  logic               medicine_reminder,
    input  logic               ack,
    output logic               alert_active,
    output logic [CODE_W-1:0]  alert_code,
    output logic               buzzer,
    output logic               escalate,
    output logic [NUM_SRC-1:0] pending
);

    localparam int unsigned MAX_A = (ESC_CYCLES > HOLDOFF_CYCLES) ? ESC_CYCLES : HOLDOFF_CYCLES;
    localparam int unsigned MAX_P = (MAX_A > BEEP_HALF) ? MAX_A : BEEP_HALF;
    localparam int unsigned CNT_W = (MAX_P > 2) ? $clog2(MAX_P) : 1;

    localparam logic [CNT_W-1:0] ESC_LAST  = CNT_W'(ESC_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] BEEP_LAST = CNT_W'(BEEP_HALF - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [NUM_SRC-1:0] r_prev;
    logic [NUM_SRC-1:0] r_pending;
    logic [CODE_W-1:0]  r_code;
    logic               r_active;
    logic               r_buzzer;
    logic               r_escalate;
    logic [CNT_W-1:0]   r_wait;
    logic [CNT_W-1:0]   r_hold;
    logic [CNT_W-1:0]   r_beep;

    logic [NUM_SRC-1:0] w_src;
    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] w_clr;
    logic [NUM_SRC-1:0] w_pending_nxt;
    logic [NUM_SRC-1:0] w_hi_pending;
    logic [CODE_W-1:0]  w_top_code;
    logic               w_top_valid;
    logic [CODE_W-1:0]  w_hi_code;
    logic               w_hi_valid;
    logic [CODE_W-1:0]  w_code_nxt;
    logic               w_active_nxt;
    logic               w_buzzer_nxt;
    logic               w_esc_nxt;
    logic [CNT_W-1:0]   w_wait_nxt;
    logic [CNT_W-1:0]   w_hold_nxt;
    logic [CNT_W-1:0]   w_beep_nxt;

    assign w_src[SRC_FALL]    = fall_alarm;
    assign w_src[SRC_BPM]     = bpm_abnormal;
    assign w_src[SRC_TEMP_HI] = temp_high;
    assign w_src[SRC_TEMP_LO] = temp_low;
    assign w_src[SRC_MED]     = medicine_reminder;

    // Rising edge per source; previous value is 0 out of reset so a held level counts once.
    assign w_rise        = w_src & ~r_prev;
    // A new edge on the served source beats its own acknowledge.
    assign w_pending_nxt = (r_pending & ~w_clr) | w_rise;
    assign w_hi_pending  = r_pending & higher_mask(r_code);

    // Highest-priority request overall, for serving from IDLE.
    alert_prio_enc u_enc_top (
        .i_pending (r_pending),
        .o_code_c  (w_top_code),
        .o_valid_c (w_top_valid)
    );

    // Highest request that outranks the one on display, for preemption.
    alert_prio_enc u_enc_hi (
        .i_pending (w_hi_pending),
        .o_code_c  (w_hi_code),
        .o_valid_c (w_hi_valid)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, counter and output decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_code_nxt   = r_code;
        w_active_nxt = r_active;
        w_buzzer_nxt = r_buzzer;
        w_esc_nxt    = r_escalate;
        w_wait_nxt   = r_wait;
        w_hold_nxt   = r_hold;
        w_beep_nxt   = r_beep;
        w_clr        = '0;
        case (r_state)
            IDLE: begin
                if (w_top_valid) begin
                    w_state_nxt  = ALERT;
                    w_code_nxt   = w_top_code;
                    w_active_nxt = 1'b1;
                    w_buzzer_nxt = 1'b1;
                    w_esc_nxt    = 1'b0;
                    w_wait_nxt   = '0;
                    w_beep_nxt   = '0;
                end
            end
            ALERT: begin
                if (ack) begin
                    w_state_nxt  = HOLDOFF;
                    w_clr        = code_bit(r_code);
                    w_code_nxt   = CODE_NONE;
                    w_active_nxt = 1'b0;
                    w_buzzer_nxt = 1'b0;
                    w_esc_nxt    = 1'b0;
                    w_hold_nxt   = '0;
                end else if (w_hi_valid) begin
                    // Preempted request stays pending; the new one restarts its timers.
                    w_code_nxt   = w_hi_code;
                    w_esc_nxt    = 1'b0;
                    w_wait_nxt   = '0;
                    w_buzzer_nxt = 1'b1;
                    w_beep_nxt   = '0;
                end else begin
                    if (r_wait == ESC_LAST) begin
                        w_esc_nxt = 1'b1;
                    end else begin
                        w_wait_nxt = r_wait + CNT_W'(1);
                    end
                    if (w_esc_nxt) begin
                        w_buzzer_nxt = 1'b1;
                    end else if (r_beep == BEEP_LAST) begin
                        w_buzzer_nxt = ~r_buzzer;
                        w_beep_nxt   = '0;
                    end else begin
                        w_beep_nxt = r_beep + CNT_W'(1);
                    end
                end
            end
            HOLDOFF: begin
                if (r_hold == HOLD_LAST) begin
                    w_state_nxt = IDLE;
                    w_hold_nxt  = '0;
                end else begin
                    w_hold_nxt = r_hold + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt  = IDLE;
                w_code_nxt   = CODE_NONE;
                w_active_nxt = 1'b0;
                w_buzzer_nxt = 1'b0;
                w_esc_nxt    = 1'b0;
            end
        endcase
    end

    // Datapath registers: edge history, pending requests, counters and outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prev     <= '0;
            r_pending  <= '0;
            r_code     <= CODE_NONE;
            r_active   <= 1'b0;
            r_buzzer   <= 1'b0;
            r_escalate <= 1'b0;
            r_wait     <= '0;
            r_hold     <= '0;
            r_beep     <= '0;
        end else begin
            r_prev     <= w_src;
            r_pending  <= w_pending_nxt;
            r_code     <= w_code_nxt;
            r_active   <= w_active_nxt;
            r_buzzer   <= w_buzzer_nxt;
            r_escalate <= w_esc_nxt;
            r_wait     <= w_wait_nxt;
            r_hold     <= w_hold_nxt;
            r_beep     <= w_beep_nxt;
        end
    end

    assign alert_active = r_active;
    assign alert_code   = r_code;
    assign buzzer       = r_buzzer;
    assign escalate     = r_escalate;
    assign pending      = r_pending;

endmodule

// File: tb/tb_patient_alert_arbiter.sv
// Scoreboard bench for patient_alert_arbiter: stimulus queues expected outputs
// tagged with a clock index; a negedge monitor pops and compares them.
module tb_patient_alert_arbiter;

    localparam logic [4:0] M_ACT  = 5'b00001;
    localparam logic [4:0] M_CODE = 5'b00010;
    localparam logic [4:0] M_BUZ  = 5'b00100;
    localparam logic [4:0] M_ESC  = 5'b01000;
    localparam logic [4:0] M_PEND = 5'b10000;
    localparam logic [4:0] M_ALL  = 5'b11111;

    logic       clk = 1'b0;
    logic       reset;
    logic       fall_alarm;
    logic       bpm_abnormal;
    logic       temp_high;
    logic       temp_low;
    logic       medicine_reminder;
    logic       ack;
    logic       alert_active;
    logic [2:0] alert_code;
    logic       buzzer;
    logic       escalate;
    logic [4:0] pending;

    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;

    typedef struct {
        int unsigned cyc;
        string       name;
        logic [4:0]  mask;
        logic        act;
        logic [2:0]  code;
        logic        buz;
        logic        esc;
        logic [4:0]  pend;
    } exp_t;

    exp_t q[$];

    patient_alert_arbiter #(
        .ESC_CYCLES     (20),
        .HOLDOFF_CYCLES (4),
        .BEEP_HALF      (3)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .fall_alarm        (fall_alarm),
        .bpm_abnormal      (bpm_abnormal),
        .temp_high         (temp_high),
        .temp_low          (temp_low),
        .medicine_reminder (medicine_reminder),
        .ack               (ack),
        .alert_active      (alert_active),
        .alert_code        (alert_code),
        .buzzer            (buzzer),
        .escalate          (escalate),
        .pending           (pending)
    );

    always #5 clk = ~clk;

    // Clock index: value k is visible from posedge k until posedge k+1.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic exp_push(input int unsigned c, input string name, input logic [4:0] mask,
                            input logic act, input logic [2:0] code, input logic buz,
                            input logic esc, input logic [4:0] pend);
        exp_t e;
        e.cyc  = c;
        e.name = name;
        e.mask = mask;
        e.act  = act;
        e.code = code;
        e.buz  = buz;
        e.esc  = esc;
        e.pend = pend;
        q.push_back(e);
    endtask

    task automatic cmp(input string name, input string fld, input int unsigned got,
                       input int unsigned want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s.%s cyc=%0d got=%0h exp=%0h", name, fld, cyc, got, want);
        end
    endtask

    task automatic check_entry(input exp_t e);
        if (e.mask[0]) cmp(e.name, "alert_active", 32'(alert_active), 32'(e.act));
        if (e.mask[1]) cmp(e.name, "alert_code",   32'(alert_code),   32'(e.code));
        if (e.mask[2]) cmp(e.name, "buzzer",       32'(buzzer),       32'(e.buz));
        if (e.mask[3]) cmp(e.name, "escalate",     32'(escalate),     32'(e.esc));
        if (e.mask[4]) cmp(e.name, "pending",      32'(pending),      32'(e.pend));
    endtask

    // Monitor: compare every queued expectation due at this clock index.
    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == cyc) begin
                check_entry(q[i]);
                q.delete(i);
            end else if (q[i].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s.missed due=%0d now=%0d", q[i].name, q[i].cyc, cyc);
                q.delete(i);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d expected end before cycle 100000", cyc);
        $fatal(1);
    end

    initial begin
        int unsigned t;
        int unsigned k;
        reset = 1'b0;
        fall_alarm = 1'b0;
        bpm_abnormal = 1'b0;
        temp_high = 1'b0;
        temp_low = 1'b0;
        medicine_reminder = 1'b0;
        ack = 1'b0;

        // Reset state, then idle with no requests.
        tick(3);
        t = cyc;
        exp_push(t + 1, "rst",  M_ALL, 1'b0, 3'd0, 1'b0, 1'b0, 5'b00000);
        exp_push(t + 4, "idle", M_ALL, 1'b0, 3'd0, 1'b0, 1'b0, 5'b00000);
        tick(2);
        reset = 1'b1;
        tick(4);

        // Single medicine event: latch, serve, beep, ack.
        t = cyc; k = t + 1;
        exp_push(k,     "s1_pend",  M_ACT | M_PEND, 1'b0, 3'd0, 1'b0, 1'b0, 5'b10000);
        exp_push(k + 1, "s1_serve", M_ALL, 1'b1, 3'd5, 1'b1, 1'b0, 5'b10000);
        exp_push(k + 3, "s1_beep1", M_ACT | M_BUZ, 1'b1, 3'd0, 1'b1, 1'b0, 5'b00000);
        exp_push(k + 4, "s1_beep0", M_ACT | M_BUZ, 1'b1, 3'd0, 1'b0, 1'b0, 5'b00000);
        exp_push(k + 5, "s1_ack",   M_ALL, 1'b0, 3'd0, 1'b0, 1'b0, 5'b00000);
        exp_push(k + 9, "s1_hold",  M_ACT, 1'b0, 3'd0, 1'b0, 1'b0, 5'b00000);
        medicine_reminder = 1'b1;
        tick(1); medicine_reminder = 1'b0;
        tick(4); ack = 1'b1;
        tick(1); ack = 1'b0;
        tick(5);

        // bpm and temp_low together; bpm held high must not re-request.
        t = cyc; k = t + 1;
        exp_push(k,      "s2_pend",    M_ACT | M_PEND, 1'b0, 3'd0, 1'b0, 1'b0, 5'b01010);
        exp_push(k + 1,  "s2_bpm",     M_ALL, 1'b1, 3'd2, 1'b1, 1'b0, 5'b01010);
        exp_push(k + 3,  "s2_ack1",    M_ALL, 1'b0, 3'd0, 1'b0, 1'b0, 5'b01000);
        exp_push(k + 7,  "s2_holdoff", M_ACT | M_PEND, 1'b0, 3'd0, 1'b0, 1'b0, 5'b01000);
        exp_push(k + 8,  "s2_tlow",    M_ALL, 1'b1, 3'd4, 1'b1, 1'b0, 5'b01000);
        exp_push(k + 10, "s2_ack2",    M_ALL, 1'b0, 3'd0, 1'b0, 1'b0, 5'b00000);
        exp_push(k + 15, "s2_level",   M_ACT | M_PEND, 1'b0, 3'd0, 1'b0, 1'b0, 5'b00000);
        bpm_abnormal = 1'b1;
        temp_low = 1'b1;
        tick(1); temp_low = 1'b0;
        tick(2); ack = 1'b1;
        tick(1); ack = 1'b0;
        tick(6); ack = 1'b1;
        tick(1); ack = 1'b0;
        tick(6); bpm_abnormal = 1'b0;
        tick(2);

        // Ack in IDLE ignored, then fall preempts medicine and medicine is re-served.
        t = cyc; k = t + 1;
        exp_push(k,      "s3_pend",    M_ACT | M_PEND, 1'b0, 3'd0, 1'b0, 1'b0, 5'b10000);
        exp_push(k + 1,  "s3_idleack", M_ALL, 1'b1, 3'd5, 1'b1, 1'b0, 5'b10000);
        exp_push(k + 2,  "s3_med",     M_ACT | M_CODE, 1'b1, 3'd5, 1'b0, 1'b0, 5'b00000);
        exp_push(k + 3,  "s3_fallpend", M_ACT | M_CODE | M_PEND, 1'b1, 3'd5, 1'b0, 1'b0, 5'b10001);
        exp_push(k + 4,  "s3_preempt", M_ACT | M_CODE | M_ESC | M_PEND, 1'b1, 3'd1, 1'b0, 1'b0, 5'b10001);
        exp_push(k + 6,  "s3_ackfall", M_ALL, 1'b0, 3'd0, 1'b0, 1'b0, 5'b10000);
        exp_push(k + 11, "s3_reserve", M_ACT | M_CODE | M_PEND, 1'b1, 3'd5, 1'b0, 1'b0, 5'b10000);
        exp_push(k + 13, "s3_ackmed",  M_ALL, 1'b0, 3'd0, 1'b0, 1'b0, 5'b00000);
        medicine_reminder = 1'b1;
        ack = 1'b1;
        tick(1); medicine_reminder = 1'b0;
        tick(1); ack = 1'b0;
        tick(1); fall_alarm = 1'b1;
        tick(1); fall_alarm = 1'b0;
        tick(2); ack = 1'b1;
        tick(1); ack = 1'b0;
        tick(6); ack = 1'b1;
        tick(1); ack = 1'b0;
        tick(5);

        // Fall held with no ack: escalation after 20 cycles in ALERT, buzzer solid.
        t = cyc; k = t + 1;
        exp_push(k,      "s4_pend",   M_ACT | M_PEND, 1'b0, 3'd0, 1'b0, 1'b0, 5'b00001);
        exp_push(k + 1,  "s4_serve",  M_ALL, 1'b1, 3'd1, 1'b1, 1'b0, 5'b00001);
        exp_push(k + 4,  "s4_toggle", M_BUZ | M_ESC, 1'b0, 3'd0, 1'b0, 1'b0, 5'b00000);
        exp_push(k + 20, "s4_noesc",  M_ALL, 1'b1, 3'd1, 1'b1, 1'b0, 5'b00001);
        exp_push(k + 21, "s4_esc",    M_ALL, 1'b1, 3'd1, 1'b1, 1'b1, 5'b00001);
        exp_push(k + 23, "s4_solid",  M_BUZ | M_ESC, 1'b0, 3'd0, 1'b1, 1'b1, 5'b00000);
        exp_push(k + 25, "s4_ack",    M_ALL, 1'b0, 3'd0, 1'b0, 1'b0, 5'b00000);
        fall_alarm = 1'b1;
        tick(25); ack = 1'b1;
        tick(1); ack = 1'b0;
        tick(5);

        // Served source toggles on the ack cycle: its bit survives and is re-served.
        t = cyc; k = t + 1;
        exp_push(k,      "s5_pend",    M_ACT | M_PEND, 1'b0, 3'd0, 1'b0, 1'b0, 5'b10000);
        exp_push(k + 1,  "s5_serve",   M_ALL, 1'b1, 3'd5, 1'b1, 1'b0, 5'b10000);
        exp_push(k + 3,  "s5_collide", M_ALL, 1'b0, 3'd0, 1'b0, 1'b0, 5'b10000);
        exp_push(k + 8,  "s5_reserve", M_ALL, 1'b1, 3'd5, 1'b1, 1'b0, 5'b10000);
        exp_push(k + 10, "s5_ack",     M_ALL, 1'b0, 3'd0, 1'b0, 1'b0, 5'b00000);
        medicine_reminder = 1'b1;
        tick(1); medicine_reminder = 1'b0;
        tick(2); medicine_reminder = 1'b1; ack = 1'b1;
        tick(1); medicine_reminder = 1'b0; ack = 1'b0;
        tick(6); ack = 1'b1;
        tick(1); ack = 1'b0;
        tick(5);

        // Asynchronous reset mid-ALERT with fall still high through release.
        t = cyc; k = t + 1;
        exp_push(k,     "s6_pend",  M_ACT | M_PEND, 1'b0, 3'd0, 1'b0, 1'b0, 5'b10000);
        exp_push(k + 1, "s6_serve", M_ALL, 1'b1, 3'd5, 1'b1, 1'b0, 5'b10000);
        exp_push(k + 2, "s6_pre",   M_ALL, 1'b1, 3'd5, 1'b1, 1'b0, 5'b10000);
        medicine_reminder = 1'b1;
        tick(1); medicine_reminder = 1'b0;
        tick(2);
        @(posedge clk);
        #2;
        reset = 1'b0;
        exp_push(k + 3, "s6_async", M_ALL, 1'b0, 3'd0, 1'b0, 1'b0, 5'b00000);
        exp_push(k + 4, "s6_inrst", M_ALL, 1'b0, 3'd0, 1'b0, 1'b0, 5'b00000);
        exp_push(k + 5, "s6_edge1", M_ACT | M_PEND, 1'b0, 3'd0, 1'b0, 1'b0, 5'b00001);
        exp_push(k + 6, "s6_edge2", M_ALL, 1'b1, 3'd1, 1'b1, 1'b0, 5'b00001);
        @(negedge clk);
        tick(1); reset = 1'b1;
        tick(4); fall_alarm = 1'b0;
        tick(2);

        // Anything still queued was never compared.
        while (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s.unchecked due=%0d", q[0].name, q[0].cyc);
            void'(q.pop_front());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/patient_alert_arbiter.md
# patient_alert_arbiter

Arbiter and sequencer that shares a single caregiver alert channel (buzzer plus alert-code display) among the patient monitors: fall detection, BPM monitor, temperature monitor (high and low) and medicine reminder. It latches each monitor's event on a rising edge and serves pending events in fixed priority. Each served alert is held until a caregiver acknowledges it. An unacknowledged alert escalates after a timeout. The block sits beside the monitors on the shared 1 MHz system clock and drives the bedside annunciator.

## Interface

Parameters:
- ESC_CYCLES, 30_000_000: cycles (30 s at 1 MHz) an alert may stay unacknowledged before `escalate` asserts.
- HOLDOFF_CYCLES, 1000: dead time after each acknowledge before the next alert is served.
- BEEP_HALF, 500_000: buzzer half-period in cycles while an alert is active and not escalated.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, 1 MHz.
- reset  in  1  asynchronous, active-low reset.
- fall_alarm  in  1  alarm from fall detection.
- bpm_abnormal  in  1  BPM monitor state flag; 1 = out of range.
- temp_high  in  1  high-temperature flag.
- temp_low  in  1  low-temperature flag.
- medicine_reminder  in  1  reminder pulse or level.
- ack  in  1  caregiver acknowledge, level-sampled.
- alert_active  out  1  an alert is being presented.
- alert_code  out  3  source being presented: 0 none, 1 fall, 2 bpm, 3 temp_high, 4 temp_low, 5 medicine.
- buzzer  out  1  audible drive.
- escalate  out  1  current alert has timed out unacknowledged.
- pending  out  5  latched requests; bit0 = fall … bit4 = medicine.

## Operation

- Each source is sampled every clock into a previous-value register, which resets to 0.
- A rising edge (sampled 1, previous 0) sets that source's `pending` bit.
- A source that stays high never re-requests.
- A source held high through reset release counts as a rising edge on the first clock.
- Priority: fall > bpm > temp_high > temp_low > medicine (lowest bit wins).
- FSM states: IDLE, ALERT, HOLDOFF.
  - IDLE: if `pending` ≠ 0, go to ALERT. Load `alert_code` for the highest-priority pending bit and clear the wait counter.
  - ALERT, ack = 1: clear the served `pending` bit; drop `alert_active`, `escalate` and `buzzer`; go to HOLDOFF.
  - ALERT, ack = 0, and a higher-priority bit than the served one is pending: preempt. Switch `alert_code` to that bit, clear the wait counter and `escalate`. The preempted bit stays pending.
  - ALERT, otherwise: increment the wait counter. When it reaches ESC_CYCLES−1, set `escalate`; it then stays set until ack or preemption. The wait counter saturates.
  - HOLDOFF: count HOLDOFF_CYCLES cycles, then go to IDLE. Edges arriving during HOLDOFF still set `pending`.
- `ack` is ignored in IDLE and HOLDOFF.
- Buzzer:
  - In ALERT with `escalate` = 0, `buzzer` toggles every BEEP_HALF cycles, starting at 1 on entry to ALERT.
  - With `escalate` = 1, `buzzer` is solid 1.
  - Outside ALERT, `buzzer` is 0.
- Simultaneous events:
  - Several rising edges in one cycle set all of their bits.
  - If ack and a new rising edge of the served source occur in the same cycle, the bit stays set (the new event wins) and is served again after HOLDOFF.
- Counter widths are sized with $clog2 of the largest parameter. All comparisons are unsigned.

## Timing

- Reset values: all outputs 0; `alert_code` = 0; state IDLE; all counters and previous-value registers 0.
- Reset asserted mid-operation clears everything immediately, including any latched pending events.
- Latency:
  - A source high at edge k with previous 0 gives `pending` bit set after edge k.
  - `alert_active` = 1 and `alert_code` valid after edge k+1.
  - `buzzer` = 1 after edge k+1.
- Ack sampled 1 at edge m gives `alert_active` = 0 after edge m.
- The next alert is served (`alert_active` = 1) after edge m+HOLDOFF_CYCLES+1.
- `escalate` asserts after the ESC_CYCLES-th clock spent in ALERT.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure

- Package `patient_alert_pkg`:
  - alert-code localparams (CODE_NONE … CODE_MED);
  - state enum (IDLE, ALERT, HOLDOFF);
  - source index constants.
- Sub-module `alert_prio_enc`: combinational 5-bit pending vector to 3-bit code plus valid flag. It is also reused for the preemption compare.
- The top level holds the edge detectors, pending register, FSM, wait/holdoff/beep counters and output registers.

## Test plan

All scenarios run with ESC_CYCLES = 20, HOLDOFF_CYCLES = 4, BEEP_HALF = 3.

- Single event: medicine rises at edge 10 → `pending` = 5'b10000 after edge 10. After edge 11: `alert_code` = 5, `alert_active` = 1, `buzzer` toggles every 3 cycles. Ack at edge 15 → `alert_active` = 0 and `pending` = 0 after edge 15.
- Simultaneous and priority: temp_low and bpm rise together → code 2 is served first. After ack plus 4 holdoff cycles, code 4 is served.
- Preemption: medicine is being served and fall_alarm rises → `alert_code` = 1 two cycles later and `pending` = 5'b10001. Ack → medicine is re-served after holdoff.
- Escalation: fall held, no ack → `escalate` = 1 after 20 cycles in ALERT and `buzzer` is solid 1. Ack → `escalate`, `buzzer` and `alert_active` go to 0.
- Level hold and ack/edge collision:
  - bpm stays high after ack → no re-request.
  - A toggle of the served source on the ack cycle → its bit stays set and it is re-served.
  - Ack in IDLE is ignored.
- Reset mid-ALERT: assert reset → all outputs 0 immediately. With fall still high at reset release → alert code 1 appears after the second edge.
